// File: rtl/pos_pkg.sv
// Shared types and constants for the pos_smooth moving-average position filter.
package pos_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UPD,
    ST_EMIT
  } pos_state_e;

  localparam int unsigned DEF_W      = 8;
  localparam int unsigned DEF_DEPTH  = 4;
  localparam int unsigned DEF_THRESH = 16;
  localparam int unsigned LOG2_DEPTH = $clog2(DEF_DEPTH);
  localparam int unsigned SUM_W      = DEF_W + LOG2_DEPTH;

  // Wide enough to hold DEPTH full-scale samples without overflow.
  function automatic int unsigned sum_width(input int unsigned w, input int unsigned depth);
    return w + $clog2(depth);
  endfunction

endpackage

// File: rtl/pos_ring.sv
// DEPTH-entry ring of packed {x, y} samples; old_o shows the slot the next write replaces.
module pos_ring import pos_pkg::*; #(
  parameter int unsigned W     = DEF_W,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           clr_i,
  input  logic           we_i,
  input  logic [2*W-1:0] wdata_i,
  output logic [2*W-1:0] old_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [2*W-1:0]  mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
    end else if (we_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
      wr_ptr_q        <= (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
  end

  assign old_o = mem_q[wr_ptr_q];

endmodule

// File: rtl/pos_smooth.sv
// Moving-average position post-filter; optional outlier rejection via POS_SMOOTH_OUTLIER_EN.
module pos_smooth import pos_pkg::*; #(
  parameter int unsigned W      = DEF_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned THRESH = DEF_THRESH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [W-1:0] xt,
  input  logic [W-1:0] yt,
  output logic         busy,
  output logic [W-1:0] xs,
  output logic [W-1:0] ys,
  output logic         smooth_valid,
  output logic         warm,
  output logic         overrun,
  output logic [7:0]   reject_cnt
);

  localparam int unsigned LogD = $clog2(DEPTH);
  localparam int unsigned SumW = sum_width(W, DEPTH);
  localparam int unsigned CntW = LogD + 1;
`ifdef POS_SMOOTH_OUTLIER_EN
  localparam bit OutlierEn = 1'b1;
`else
  localparam bit OutlierEn = 1'b0;
`endif

  pos_state_e  state_q, state_d;
  logic [W-1:0]    nx_q, nx_d, ny_q, ny_d;
  logic [W-1:0]    xs_q, xs_d, ys_q, ys_d;
  logic [SumW-1:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sv_q, sv_d, warm_q, warm_d, overrun_q, overrun_d;
  logic [2*W-1:0]  old_xy;
  logic [W-1:0]    old_x, old_y, dx, dy;
  logic [SumW-1:0] avg_x, avg_y;
  logic            reject, ring_we;

  assign old_x = old_xy[2*W-1:W];
  assign old_y = old_xy[W-1:0];
  assign avg_x = sum_x_q >> LogD;
  assign avg_y = sum_y_q >> LogD;

  assign dx     = (xt >= xs_q) ? xt - xs_q : xs_q - xt;
  assign dy     = (yt >= ys_q) ? yt - ys_q : ys_q - yt;
  assign reject = OutlierEn && warm_q && ((32'(dx) > THRESH) || (32'(dy) > THRESH));

  assign ring_we = (state_q == ST_UPD) && !clr;

  pos_ring #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk_i   (clk),
    .rst_ni  (rst),
    .clr_i   (clr),
    .we_i    (ring_we),
    .wdata_i ({nx_q, ny_q}),
    .old_o   (old_xy)
  );

  always_comb begin
    state_d   = state_q;
    nx_d      = nx_q;
    ny_d      = ny_q;
    xs_d      = xs_q;
    ys_d      = ys_q;
    sum_x_d   = sum_x_q;
    sum_y_d   = sum_y_q;
    cnt_d     = cnt_q;
    sv_d      = 1'b0;
    warm_d    = warm_q;
    overrun_d = overrun_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && !reject) begin
          nx_d    = xt;
          ny_d    = yt;
          state_d = ST_UPD;
        end
      end
      ST_UPD: begin
        sum_x_d = sum_x_q + SumW'(nx_q) - SumW'(old_x);
        sum_y_d = sum_y_q + SumW'(ny_q) - SumW'(old_y);
        cnt_d   = (cnt_q == CntW'(DEPTH)) ? cnt_q : cnt_q + CntW'(1);
        state_d = ST_EMIT;
        if (in_valid) overrun_d = 1'b1;
      end
      ST_EMIT: begin
        if (cnt_q == CntW'(DEPTH)) begin
          xs_d   = avg_x[W-1:0];
          ys_d   = avg_y[W-1:0];
          warm_d = 1'b1;
        end else begin
          xs_d = nx_q;
          ys_d = ny_q;
        end
        sv_d    = 1'b1;
        state_d = ST_IDLE;
        if (in_valid) overrun_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (clr) begin
      state_d   = ST_IDLE;
      xs_d      = '0;
      ys_d      = '0;
      sum_x_d   = '0;
      sum_y_d   = '0;
      cnt_d     = '0;
      sv_d      = 1'b0;
      warm_d    = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      nx_q      <= '0;
      ny_q      <= '0;
      xs_q      <= '0;
      ys_q      <= '0;
      sum_x_q   <= '0;
      sum_y_q   <= '0;
      cnt_q     <= '0;
      sv_q      <= 1'b0;
      warm_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      nx_q      <= nx_d;
      ny_q      <= ny_d;
      xs_q      <= xs_d;
      ys_q      <= ys_d;
      sum_x_q   <= sum_x_d;
      sum_y_q   <= sum_y_d;
      cnt_q     <= cnt_d;
      sv_q      <= sv_d;
      warm_q    <= warm_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef POS_SMOOTH_OUTLIER_EN
  logic [7:0] rej_q, rej_d;

  always_comb begin
    rej_d = rej_q;
    if (clr) begin
      rej_d = '0;
    end else if ((state_q == ST_IDLE) && in_valid && reject && (rej_q != 8'hFF)) begin
      rej_d = rej_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rej_q <= '0;
    else      rej_q <= rej_d;
  end

  assign reject_cnt = rej_q;
`else
  assign reject_cnt = '0;
`endif

  assign busy         = (state_q != ST_IDLE);
  assign xs           = xs_q;
  assign ys           = ys_q;
  assign smooth_valid = sv_q;
  assign warm         = warm_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_pos_smooth.sv
// Scoreboard bench for pos_smooth: stimulus pushes expected outputs, a monitor pops on smooth_valid.
module tb_pos_smooth;
  import pos_pkg::*;

  localparam int unsigned W      = DEF_W;
  localparam int unsigned DEPTH  = DEF_DEPTH;
  localparam int unsigned THRESH = DEF_THRESH;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         w;
  } exp_t;

  logic         clk, rst, clr, in_valid;
  logic [W-1:0] xt, yt, xs, ys;
  logic         busy, smooth_valid, warm, overrun;
  logic [7:0]   reject_cnt;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  pos_smooth #(
    .W      (W),
    .DEPTH  (DEPTH),
    .THRESH (THRESH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .in_valid     (in_valid),
    .xt           (xt),
    .yt           (yt),
    .busy         (busy),
    .xs           (xs),
    .ys           (ys),
    .smooth_valid (smooth_valid),
    .warm         (warm),
    .overrun      (overrun),
    .reject_cnt   (reject_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst && smooth_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_smooth_valid: got xs=%0d ys=%0d, expected no pulse", xs, ys);
      end else begin
        mon_e = exp_q.pop_front();
        check("xs", int'(xs), int'(mon_e.x));
        check("ys", int'(ys), int'(mon_e.y));
        check("warm", int'(warm), int'(mon_e.w));
      end
    end
  end

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_xs"}, int'(xs), 0);
    check({tag, "_ys"}, int'(ys), 0);
    check({tag, "_smooth_valid"}, int'(smooth_valid), 0);
    check({tag, "_warm"}, int'(warm), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
    check({tag, "_reject_cnt"}, int'(reject_cnt), 0);
  endtask

  // Drives a one-cycle pulse at a negedge, then idles three cycles so the result drains.
  task automatic send(input int x, input int y, input bit push, input int ex, input int ey,
                      input int ew);
    exp_t e;
    if (push) begin
      e.x = W'(ex);
      e.y = W'(ey);
      e.w = ew[0];
      exp_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b1;
    xt       = W'(x);
    yt       = W'(y);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst      = 1'b0;
    clr      = 1'b0;
    in_valid = 1'b0;
    xt       = '0;
    yt       = '0;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b1;

    // Sample in flight when reset hits: it must vanish.
    @(negedge clk);
    in_valid = 1'b1;
    xt       = 8'd77;
    yt       = 8'd77;
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    check_idle_zero("midreset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Fill the window, then wrap.
    send(10, 20, 1'b1, 10, 20, 0);
    send(12, 22, 1'b1, 12, 22, 0);
    send(14, 24, 1'b1, 14, 24, 0);
    check("warm_before_full", int'(warm), 0);
    send(16, 26, 1'b1, 13, 23, 1);
    send(30, 30, 1'b1, 18, 25, 1);
    check("overrun_before", int'(overrun), 0);

    // Second pulse lands in UPD and is dropped.
    exp_q.push_back('{x: 8'd20, y: 8'd25, w: 1'b1});
    @(negedge clk);
    in_valid = 1'b1;
    xt       = 8'd20;
    yt       = 8'd20;
    @(negedge clk);
    xt = 8'd99;
    yt = 8'd99;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("overrun_set", int'(overrun), 1);
    send(20, 20, 1'b1, 21, 24, 1);
    check("overrun_sticky", int'(overrun), 1);

    // Flush during UPD aborts the sample.
    @(negedge clk);
    in_valid = 1'b1;
    xt       = 8'd50;
    yt       = 8'd50;
    @(negedge clk);
    in_valid = 1'b0;
    clr      = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (4) @(negedge clk);
    check_idle_zero("flush");

    // Cleared ring and sums: passthrough again, then an exact average.
    send(10, 20, 1'b1, 10, 20, 0);
    send(2, 4, 1'b1, 2, 4, 0);
    send(2, 4, 1'b1, 2, 4, 0);
    send(2, 4, 1'b1, 4, 8, 1);

`ifdef POS_SMOOTH_OUTLIER_EN
    send(40, 8, 1'b0, 0, 0, 0);
    check("reject_cnt_one", int'(reject_cnt), 1);
    send(20, 8, 1'b1, 6, 5, 1);
    check("reject_cnt_hold", int'(reject_cnt), 1);
`else
    send(40, 8, 1'b1, 11, 5, 1);
    check("reject_cnt_tied", int'(reject_cnt), 0);
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pos_smooth.md
# pos_smooth

Downstream position post-filter for the RSSI trilateration datapath. It consumes each `(xt, yt)` estimate as it is produced, qualified by the one-cycle `out_valid` pulse. It keeps the last DEPTH estimates in a ring buffer with running sums and emits a moving-average position, so the reported location no longer jitters sample-to-sample. The upstream stage has no backpressure, so this block accepts or flags every pulse and never stalls its producer.

## Interface
- `W`, default 8: coordinate width, matching `xt`/`yt`.
- `DEPTH`, default 4: averaging window length; must be a power of two, range 2..16.
- `THRESH`, default 16: outlier distance limit per axis, in coordinate units (used only with the macro).
- `clk`, input, 1: system clock, rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `clr`, input, 1: synchronous flush of the window.
- `in_valid`, input, 1: connects to upstream `out_valid`.
- `xt`, input, W: raw x estimate.
- `yt`, input, W: raw y estimate.
- `busy`, output, 1: high while a sample is being processed.
- `xs`, output, W: smoothed x.
- `ys`, output, W: smoothed y.
- `smooth_valid`, output, 1: one-cycle pulse when `xs`/`ys` are updated.
- `warm`, output, 1: window full; outputs are true averages.
- `overrun`, output, 1: sticky; a pulse arrived while busy.
- `reject_cnt`, output, 8: saturating count of outlier drops.

## Operation
- FSM states are IDLE, UPD and EMIT. `busy` = (state != IDLE).
- **IDLE:** on `in_valid`, latch `xt`/`yt` into `nx`/`ny` and go to UPD.
- **UPD:**
  - Write `nx`/`ny` into the ring at `wr_ptr`.
  - Update the sums: `sum_x <= sum_x + nx - old_x`, where `old_x` is the entry being overwritten. Same for y.
  - `wr_ptr` wraps from DEPTH-1 to 0.
  - `cnt` increments and saturates at DEPTH.
  - Go to EMIT.
- **EMIT:**
  - If `cnt == DEPTH`: `xs = sum_x >> log2(DEPTH)` (truncating) and `warm = 1`.
  - Otherwise: `xs = nx` (passthrough).
  - y is handled the same way.
  - Pulse `smooth_valid` and go to IDLE.
- **Sum width:** W + log2(DEPTH) bits, unsigned. It never overflows because it always equals the sum of the ring contents.
- **Empty slots:** ring entries not yet written read as 0, so the sum stays exact during fill.
- **Pulse while busy:** an `in_valid` seen in UPD or EMIT is dropped and sets `overrun`. Only `clr` or reset clears `overrun`.
- **`clr` priority:** `clr` overrides `in_valid` and all FSM activity.
  - Zeroes the ring, sums, `cnt`, `wr_ptr`, `xs`, `ys`, `warm`, `overrun` and `reject_cnt`.
  - Forces the state to IDLE with no `smooth_valid`.
  - A `clr` arriving mid-UPD or mid-EMIT aborts that sample.

## Timing
- **Reset values:** all outputs are 0 (`busy`, `xs`, `ys`, `smooth_valid`, `warm`, `overrun`, `reject_cnt`). State is IDLE; ring, sums and pointers are zero.
- **Latency:** a sample accepted at edge E0 produces the `smooth_valid` pulse in the cycle after E2 (two-cycle latency). `xs`/`ys` are updated at the same edge and then held.
- **Throughput:** the next sample is accepted no earlier than E3. Minimum input spacing is 3 cycles; upstream spacing is much larger in practice.
- **Window boundaries:**
  - The DEPTH-th accepted sample is the first averaged output, with `warm` rising together with its `smooth_valid`.
  - `warm` stays high until `clr` or reset.
- **Wrap-around:** the slot overwritten at `wr_ptr` wrap is always the oldest entry.

## Configuration
- **`POS_SMOOTH_OUTLIER_EN` defined:**
  - In IDLE with `warm = 1`, an incoming sample with |xt - xs| > THRESH or |yt - ys| > THRESH is rejected.
  - A rejected sample causes no state change and no `smooth_valid`, and `reject_cnt` increments (saturating at 255).
  - The comparison is unsigned absolute difference.
  - No rejection happens while not warm.
- **Macro undefined:** every sample is accepted, `reject_cnt` is tied to 0, and `THRESH` is ignored.

## Structure
- **Package `pos_pkg`:**
  - FSM state enum (`ST_IDLE`, `ST_UPD`, `ST_EMIT`).
  - Default W/DEPTH/THRESH constants.
  - A `clog2`-derived `LOG2_DEPTH` constant.
  - Sum-width localparam.
- **Sub-module `pos_ring`:** DEPTH x 2W register ring with `wr_ptr`, write-enable, an old-entry read port and synchronous clear. The top level holds the FSM, sums, divide-by-shift and outlier logic.

## Test plan
- **Reset:** hold `rst` low mid-stream, then release. All outputs read 0, `busy` = 0, and the first sample (10,20) emits `xs`/`ys` = 10/20 with `warm` = 0, two cycles later.
- **Fill and average (DEPTH = 4):** samples (10,20), (12,22), (14,24), (16,26). Fourth output is (13,23) with `warm` = 1.
- **Wrap:** fifth sample (30,30) replaces (10,20); sums are 72 and 102. Output is (18,25).
- **Overrun:** `in_valid` pulse one cycle after an accepted sample. The pulse is dropped, `overrun` = 1, and the ring is unchanged.
- **Flush:** `clr` asserted during UPD. No `smooth_valid`; all outputs, `cnt` and sums are 0.
- **Outlier (macro on, THRESH = 16, `xs` = 13):** sample (40,23) → no `smooth_valid`, `reject_cnt` = 1. Sample (20,23) → accepted.
